// File: rtl/cpu_clk_sched_pkg.sv
// Shared encodings and divisor selection for the CPU clock-enable scheduler.
package cpu_clk_pkg;

    localparam int unsigned DIV_W = 32;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'b00,
        ST_RUN   = 2'b01,
        ST_HALT  = 2'b10
    } st_e;

    function automatic logic [DIV_W-1:0] div_sel(
        input logic [1:0]       sel,
        input logic [DIV_W-1:0] d0,
        input logic [DIV_W-1:0] d1,
        input logic [DIV_W-1:0] d2,
        input logic [DIV_W-1:0] d3
    );
        logic [DIV_W-1:0] r;
        case (sel)
            2'd0:    r = d0;
            2'd1:    r = d1;
            2'd2:    r = d2;
            default: r = d3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_clk_sched_debounce.sv
// Button synchroniser, debouncer and single-cycle rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          s1_q, s2_q;
    logic [1:0]    vld_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d, lvl_dly_q;
    logic          armed_q, armed_d;
    logic          pulse_q;

    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (s2_q != lvl_q) begin
            if (cnt_q == CNT_MAX) begin
                lvl_d = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // A button held through reset must be seen released before it can step.
    assign armed_d = armed_q | (vld_q[1] & ~s2_q & ~lvl_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            vld_q     <= 2'b00;
            cnt_q     <= '0;
            lvl_q     <= 1'b0;
            lvl_dly_q <= 1'b0;
            armed_q   <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            s1_q      <= btn_i;
            s2_q      <= s1_q;
            vld_q     <= {vld_q[0], 1'b1};
            cnt_q     <= cnt_d;
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_q;
            armed_q   <= armed_d;
            pulse_q   <= armed_q & lvl_q & ~lvl_dly_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_clk_sched.sv
// CPU clock-enable scheduler: free-run divider, pause, single-step and halt.
module cpu_clk_sched
    import cpu_clk_pkg::*;
#(
    parameter int unsigned DIV0       = 1,
    parameter int unsigned DIV1       = 100,
    parameter int unsigned DIV2       = 100000,
    parameter int unsigned DIV3       = 25000000,
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             I_CLK,
    input  logic             rst,
    input  logic             run_sw,
    input  logic [1:0]       speed_sel,
    input  logic             step_btn,
    input  logic             halt_req,
    output logic             cpu_ce,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] tick_cnt
);

    st_e              state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_eff;
    logic [CNT_W-1:0] tick_q;
    logic             step_pulse;
    logic             tick_hit;
    logic             ce;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk_i  (I_CLK),
        .rst_i  (rst),
        .btn_i  (step_btn),
        .pulse_o(step_pulse)
    );

    // New rate only takes effect at a period boundary.
    assign div_eff = (cnt_q == '0)
                   ? div_sel(speed_sel, DIV_W'(DIV0), DIV_W'(DIV1),
                             DIV_W'(DIV2), DIV_W'(DIV3))
                   : div_q;
    assign tick_hit = (cnt_q == div_eff - DIV_W'(1));

    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            state_q <= ST_PAUSE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_PAUSE: begin
                if (ce && halt_req) state_d = ST_HALT;
                else if (run_sw)    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ce && halt_req) state_d = ST_HALT;
                else if (!run_sw)   state_d = ST_PAUSE;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_PAUSE;
        endcase
    end

    always_comb begin
        ce = 1'b0;
        unique case (state_q)
            ST_PAUSE: ce = step_pulse;
            ST_RUN:   ce = tick_hit;
            default:  ce = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (state_q == ST_RUN && run_sw && !(ce && halt_req) && !tick_hit) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= DIV_W'(DIV0);
            tick_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_eff;
            tick_q <= tick_q + CNT_W'(ce);
        end
    end

    assign cpu_ce   = ce;
    assign state    = state_q;
    assign tick_cnt = tick_q;

endmodule

// File: tb/tb_cpu_clk_sched.sv
// Self-checking bench for cpu_clk_sched with a cycle model and directed checks.
module tb_cpu_clk_sched;

    localparam int DEB = 5;
    localparam int CW  = 4;

    logic          I_CLK = 1'b0;
    logic          rst = 1'b1;
    logic          run_sw = 1'b0;
    logic [1:0]    speed_sel = 2'd0;
    logic          step_btn = 1'b0;
    logic          halt_req = 1'b0;
    logic          cpu_ce;
    logic [1:0]    state;
    logic [CW-1:0] tick_cnt;

    int n_chk = 0;
    int n_fail = 0;

    cpu_clk_sched #(
        .DIV0(1), .DIV1(4), .DIV2(7), .DIV3(10),
        .DEB_CYCLES(DEB), .CNT_W(CW)
    ) dut (
        .I_CLK    (I_CLK),
        .rst      (rst),
        .run_sw   (run_sw),
        .speed_sel(speed_sel),
        .step_btn (step_btn),
        .halt_req (halt_req),
        .cpu_ce   (cpu_ce),
        .state    (state),
        .tick_cnt (tick_cnt)
    );

    always #5 I_CLK = ~I_CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int div_of(input logic [1:0] s);
        case (s)
            2'd0: return 1;
            2'd1: return 4;
            2'd2: return 7;
            default: return 10;
        endcase
    endfunction

    // Model: 0 pause, 1 run, 2 halt; 'since' = cycles into the current period.
    int ms = 0, since = 0, plen = 1, mtick = 0;
    int rawh[$];
    int dq[$];
    int mlvl = 0, mlvl_prev = 0, marm = 0, mpulse = 0;

    always @(negedge I_CLK) begin
        int ecur, s2, s2v, nlvl, npulse, alldiff;
        bit ece;
        if (rst) begin
            ms = 0; since = 0; plen = 1; mtick = 0;
            rawh = {-1, -1}; dq = {};
            mlvl = 0; mlvl_prev = 0; marm = 0; mpulse = 0;
        end
        ecur = (since == 0) ? div_of(speed_sel) : plen;
        ece  = !rst && ((ms == 1 && since + 1 == ecur) || (ms == 0 && mpulse != 0));
        chk("model_ce", cpu_ce, ece);
        chk("model_state", state, ms);
        chk("model_tick", tick_cnt, mtick);
        if (!rst) begin
            plen = ecur;
            if (ece) mtick = (mtick + 1) % (1 << CW);
            if (ms != 2) begin
                if (ece && halt_req) ms = 2;
                else if (ms == 1) begin
                    if (!run_sw) begin ms = 0; since = 0; end
                    else since = ece ? 0 : since + 1;
                end else if (run_sw) begin
                    ms = 1; since = 0;
                end
            end
            s2  = rawh[0];
            s2v = (s2 < 0) ? 0 : s2;
            nlvl = mlvl;
            dq.push_back(s2v);
            if (dq.size() > DEB) void'(dq.pop_front());
            alldiff = (dq.size() == DEB);
            foreach (dq[i]) if (dq[i] == mlvl) alldiff = 0;
            if (alldiff != 0) begin nlvl = 1 - mlvl; dq = {}; end
            npulse = (marm != 0 && mlvl == 1 && mlvl_prev == 0) ? 1 : 0;
            if (s2 == 0 && mlvl == 0) marm = 1;
            mlvl_prev = mlvl;
            mlvl = nlvl;
            mpulse = npulse;
            rawh.push_back(int'(step_btn));
            void'(rawh.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge I_CLK);
        #1;
    endtask

    initial begin
        cyc(3);
        chk("rst_state", state, 0);
        chk("rst_tick", tick_cnt, 0);
        chk("rst_ce", cpu_ce, 0);
        rst = 1'b0;
        cyc(5);

        speed_sel = 2'd1; run_sw = 1'b1;
        cyc(1);
        chk("run_entry_state", state, 1);
        cyc(3);
        chk("run_ce_c4", cpu_ce, 1);
        cyc(8);
        chk("run_ce_c12", cpu_ce, 1);
        cyc(1);
        chk("run_tick3", tick_cnt, 3);

        cyc(2);
        speed_sel = 2'd2;
        cyc(1);
        chk("latch_old_period", cpu_ce, 1);
        cyc(6);
        chk("latch_new_c22", cpu_ce, 0);
        cyc(1);
        chk("latch_new_c23", cpu_ce, 1);
        cyc(1);
        run_sw = 1'b0;
        cyc(1);
        chk("pause_state", state, 0);
        chk("pause_tick", tick_cnt, 5);

        for (int b = 0; b < 3; b++) begin
            step_btn = 1'b1; cyc(2);
            step_btn = 1'b0; cyc(2);
        end
        step_btn = 1'b1;
        cyc(7);
        chk("step_early", cpu_ce, 0);
        cyc(1);
        chk("step_ce", cpu_ce, 1);
        cyc(1);
        chk("step_tick", tick_cnt, 6);
        cyc(20);
        chk("step_hold_tick", tick_cnt, 6);
        step_btn = 1'b0;
        cyc(12);

        speed_sel = 2'd1; step_btn = 1'b1;
        cyc(8);
        chk("simul_step_ce", cpu_ce, 1);
        run_sw = 1'b1;
        cyc(1);
        chk("simul_run_state", state, 1);
        chk("simul_tick", tick_cnt, 7);
        cyc(3);
        chk("simul_run_ce", cpu_ce, 1);
        cyc(1);
        run_sw = 1'b0; step_btn = 1'b0;
        cyc(1);
        chk("simul_pause_tick", tick_cnt, 8);
        cyc(10);

        rst = 1'b1; cyc(2); rst = 1'b0; cyc(5);
        speed_sel = 2'd0; run_sw = 1'b1;
        cyc(1);
        chk("halt_first_ce", cpu_ce, 1);
        cyc(4);
        halt_req = 1'b1;
        chk("halt_fifth_ce", cpu_ce, 1);
        cyc(1);
        halt_req = 1'b0;
        chk("halt_state", state, 2);
        chk("halt_tick", tick_cnt, 5);
        run_sw = 1'b0; cyc(3);
        run_sw = 1'b1; step_btn = 1'b1; cyc(12);
        step_btn = 1'b0; run_sw = 1'b0; cyc(10);
        chk("halt_stay_state", state, 2);
        chk("halt_stay_tick", tick_cnt, 5);
        rst = 1'b1;
        #2;
        chk("halt_rst_state", state, 0);
        chk("halt_rst_tick", tick_cnt, 0);
        cyc(2); rst = 1'b0; cyc(5);

        halt_req = 1'b1; cyc(4);
        chk("halt_paused_ign", state, 0);
        halt_req = 1'b0;

        speed_sel = 2'd0; run_sw = 1'b1;
        cyc(1);
        cyc(16);
        run_sw = 1'b0;
        chk("wrap_last_ce", cpu_ce, 1);
        cyc(1);
        chk("wrap_state", state, 0);
        chk("wrap_tick", tick_cnt, 1);

        speed_sel = 2'd1; run_sw = 1'b1;
        cyc(3);
        step_btn = 1'b1;
        cyc(4);
        rst = 1'b1; run_sw = 1'b0;
        #2;
        chk("midrst_state", state, 0);
        chk("midrst_tick", tick_cnt, 0);
        chk("midrst_ce", cpu_ce, 0);
        cyc(2); rst = 1'b0;
        cyc(20);
        chk("held_no_step", tick_cnt, 0);
        step_btn = 1'b0; cyc(12);
        step_btn = 1'b1; cyc(8);
        chk("repress_ce", cpu_ce, 1);
        cyc(1);
        chk("repress_tick", tick_cnt, 1);
        step_btn = 1'b0; cyc(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
